// File: rtl/game_menu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_menu_ctrl_pkg
// Description : Shared constants for the game menu controller: FSM state
//               encoding, display-source codes, speed limits and a helper
//               that applies one saturating speed step.
// Revision    : 1.0 - initial release
// ============================================================================
package game_menu_ctrl_pkg;

  // FSM state encoding (also visible on state_o)
  localparam logic [2:0] c_ST_MENU   = 3'd0;
  localparam logic [2:0] c_ST_LAUNCH = 3'd1;
  localparam logic [2:0] c_ST_PLAY1  = 3'd2;
  localparam logic [2:0] c_ST_PLAY2  = 3'd3;
  localparam logic [2:0] c_ST_RETURN = 3'd4;

  // vgaMUX source codes
  localparam logic [1:0] c_VGA_BG    = 2'd0;
  localparam logic [1:0] c_VGA_GAME1 = 2'd1;
  localparam logic [1:0] c_VGA_GAME2 = 2'd2;

  // speedcontrol saturation limits
  localparam logic [3:0] c_SPEED_MIN = 4'd1;
  localparam logic [3:0] c_SPEED_MAX = 4'd15;

  // One saturating speed step; opposing requests cancel out.
  function automatic logic [3:0] speed_step(input logic [3:0] cur,
                                            input logic       inc,
                                            input logic       dec);
    logic [3:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != c_SPEED_MAX)) begin
      nxt = cur + 4'd1;
    end else if (dec && !inc && (cur != c_SPEED_MIN)) begin
      nxt = cur - 4'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_menu_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : 1-bit rising-edge detector. The history register samples the
//               level every cycle, so a held level produces one pulse only.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset (clears history)
//               i_level - debounced level input, active-high
//               o_rise  - high while level is 1 and previous sample was 0
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/game_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_menu_ctrl
// Description : Menu/launch controller for a two-game console. Moves a cursor
//               and a speed setting in the menu, holds the games in reset for
//               RST_CYCLES cycles on launch, routes the selected game to the
//               display and returns to the menu on exit once all inputs are
//               released. All outputs are registered.
// Ports       : sys_clk, sys_rst_n          - clock, async active-low reset
//               button_up/down/left/right   - cursor / speed buttons (levels)
//               start_in                    - confirm button (level)
//               exit                        - exit request (level)
//               vgaMUX[1:0]                 - display source (0 bg, 1/2 game)
//               choice[1:0]                 - menu cursor (0 game1, 1 game2)
//               gamein_rst                  - active-high reset to the games
//               speedcontrol[3:0]           - game speed, 1..15
//               state_o[2:0]                - current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module game_menu_ctrl
  import game_menu_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned SPEED_RESET = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       button_left,
  input  logic       button_right,
  input  logic       start_in,
  input  logic       exit,
  output logic [1:0] vgaMUX,
  output logic [1:0] choice,
  output logic       gamein_rst,
  output logic [3:0] speedcontrol,
  output logic [2:0] state_o
);

  localparam int         c_N_IN     = 6;
  localparam int         c_IDX_UP   = 0;
  localparam int         c_IDX_DN   = 1;
  localparam int         c_IDX_LT   = 2;
  localparam int         c_IDX_RT   = 3;
  localparam int         c_IDX_ST   = 4;
  localparam int         c_IDX_EX   = 5;
  localparam logic [15:0] c_CNT_LAST = 16'(RST_CYCLES - 1);
  localparam logic [3:0]  c_SPEED_RST = 4'(SPEED_RESET);

  logic [c_N_IN-1:0] w_level;
  logic [c_N_IN-1:0] w_rise;

  assign w_level = {exit, start_in, button_right, button_left, button_down, button_up};

  for (genvar gi = 0; gi < c_N_IN; gi++) begin : g_edge
    btn_edge u_edge (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .i_level (w_level[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // Registered state and outputs
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic        r_target;   // 0 = game 1, 1 = game 2
  logic [1:0]  r_choice;
  logic [3:0]  r_speed;
  logic [1:0]  r_vga;
  logic        r_gamein_rst;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_target_nxt;
  logic [1:0]  w_choice_nxt;
  logic [3:0]  w_speed_nxt;
  logic [1:0]  w_vga_nxt;
  logic        w_gamein_rst_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_choice_nxt = r_choice;
    w_speed_nxt  = r_speed;

    case (r_state)
      c_ST_MENU: begin
        // Speed adjusts in the menu regardless of a simultaneous start.
        w_speed_nxt = speed_step(r_speed, w_rise[c_IDX_RT], w_rise[c_IDX_LT]);
        if (w_rise[c_IDX_ST]) begin
          // Launch with the cursor as it stands; a same-cycle cursor edge is dropped.
          w_state_nxt  = c_ST_LAUNCH;
          w_target_nxt = r_choice[0];
          w_cnt_nxt    = 16'd0;
        end else if (w_rise[c_IDX_UP] ^ w_rise[c_IDX_DN]) begin
          // With two entries, wrap-around up and down both toggle the cursor.
          w_choice_nxt = (r_choice == 2'd0) ? 2'd1 : 2'd0;
        end
      end
      c_ST_LAUNCH: begin
        if (w_rise[c_IDX_EX]) begin
          w_state_nxt = c_ST_RETURN;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = r_target ? c_ST_PLAY2 : c_ST_PLAY1;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      c_ST_PLAY1, c_ST_PLAY2: begin
        if (w_rise[c_IDX_EX]) begin
          w_state_nxt = c_ST_RETURN;
        end
      end
      c_ST_RETURN: begin
        // Wait for every input to be released so nothing carries into the menu.
        if (w_level == '0) begin
          w_state_nxt = c_ST_MENU;
        end
      end
      default: begin
        w_state_nxt = c_ST_MENU;
        w_cnt_nxt   = 16'd0;
      end
    endcase

    // Outputs are decoded from the next state so they land in the same edge.
    case (w_state_nxt)
      c_ST_LAUNCH: begin
        w_vga_nxt        = w_target_nxt ? c_VGA_GAME2 : c_VGA_GAME1;
        w_gamein_rst_nxt = 1'b1;
      end
      c_ST_PLAY1: begin
        w_vga_nxt        = c_VGA_GAME1;
        w_gamein_rst_nxt = 1'b0;
      end
      c_ST_PLAY2: begin
        w_vga_nxt        = c_VGA_GAME2;
        w_gamein_rst_nxt = 1'b0;
      end
      default: begin
        w_vga_nxt        = c_VGA_BG;
        w_gamein_rst_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= c_ST_MENU;
      r_cnt        <= 16'd0;
      r_target     <= 1'b0;
      r_choice     <= 2'd0;
      r_speed      <= c_SPEED_RST;
      r_vga        <= c_VGA_BG;
      r_gamein_rst <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_target     <= w_target_nxt;
      r_choice     <= w_choice_nxt;
      r_speed      <= w_speed_nxt;
      r_vga        <= w_vga_nxt;
      r_gamein_rst <= w_gamein_rst_nxt;
    end
  end

  assign vgaMUX       = r_vga;
  assign choice       = r_choice;
  assign gamein_rst   = r_gamein_rst;
  assign speedcontrol = r_speed;
  assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_menu_ctrl
// Description : Directed, self-checking bench for game_menu_ctrl. Each stimulus
//               step pushes the hand-computed expected outputs for the
//               following clock edge into a queue; a monitor pops and compares
//               after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_menu_ctrl;

  localparam logic [2:0] S_MENU = 3'd0, S_LAUNCH = 3'd1, S_PLAY1 = 3'd2,
                         S_PLAY2 = 3'd3, S_RETURN = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       b_up, b_dn, b_lt, b_rt, b_st, b_ex;
  logic [1:0] vga, choice;
  logic       grst;
  logic [3:0] speed;
  logic [2:0] state;

  game_menu_ctrl #(.RST_CYCLES(16), .SPEED_RESET(8)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .button_up    (b_up),
    .button_down  (b_dn),
    .button_left  (b_lt),
    .button_right (b_rt),
    .start_in     (b_st),
    .exit         (b_ex),
    .vgaMUX       (vga),
    .choice       (choice),
    .gamein_rst   (grst),
    .speedcontrol (speed),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       chk;
    logic [2:0] st;
    logic [1:0] vga;
    logic [1:0] ch;
    logic       rst;
    logic [3:0] spd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;

  // Expected outputs after the next rising edge, maintained by hand below.
  logic [2:0] e_st;
  logic [1:0] e_vga, e_ch;
  logic       e_rst;
  logic [3:0] e_spd;

  task automatic chk_val(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input logic u, input logic d, input logic l, input logic r,
                      input logic s, input logic x, input bit chk);
    exp_t e;
    @(negedge clk);
    b_up = u; b_dn = d; b_lt = l; b_rt = r; b_st = s; b_ex = x;
    e.chk = chk; e.st = e_st; e.vga = e_vga; e.ch = e_ch; e.rst = e_rst; e.spd = e_spd;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit chk);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, chk);
  endtask

  // Monitor: one expectation per rising edge, compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_pop++;
        if (e.chk) begin
          n_checks++;
          if ({state, vga, choice, grst, speed} != {e.st, e.vga, e.ch, e.rst, e.spd}) begin
            n_fail++;
            $display("FAIL sb[%0d] st/vga/ch/rst/spd got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                     n_pop, state, vga, choice, grst, speed, e.st, e.vga, e.ch, e.rst, e.spd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_reset_exp();
    e_st = S_MENU; e_vga = 2'd0; e_ch = 2'd0; e_rst = 1'b1; e_spd = 4'd8;
  endtask

  initial begin
    rst_n = 1'b0;
    b_up = 0; b_dn = 0; b_lt = 0; b_rt = 0; b_st = 0; b_ex = 0;
    set_reset_exp();
    repeat (2) @(negedge clk);
    idle(1, 1);                               // reset values held
    @(negedge clk); rst_n = 1'b1;
    idle(1, 1);

    // Cursor: down, down, up, held level, simultaneous up+down
    e_ch = 2'd1; step(0, 1, 0, 0, 0, 0, 1); idle(1, 1);
    e_ch = 2'd0; step(0, 1, 0, 0, 0, 0, 1); idle(1, 1);
    e_ch = 2'd1; step(1, 0, 0, 0, 0, 0, 1); idle(1, 1);
    e_ch = 2'd0; step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);                // held, no second edge
    idle(1, 1);
    step(1, 1, 0, 0, 0, 0, 1); idle(1, 1);    // opposing edges cancel

    // Speed saturation
    for (int i = 0; i < 10; i++) begin step(0, 0, 0, 1, 0, 0, 0); idle(1, 0); end
    e_spd = 4'd15; idle(1, 1);
    step(0, 0, 1, 1, 0, 0, 1); idle(1, 1);    // opposing edges cancel
    for (int i = 0; i < 20; i++) begin step(0, 0, 1, 0, 0, 0, 0); idle(1, 0); end
    e_spd = 4'd1; idle(1, 1);
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 1, 0, 0, 0); idle(1, 0); end
    e_spd = 4'd3; idle(1, 1);

    // Launch game 2: exactly 16 cycles in LAUNCH, then PLAY2
    e_ch = 2'd1; step(0, 1, 0, 0, 0, 0, 1); idle(1, 1);
    e_st = S_LAUNCH; e_vga = 2'd2; e_rst = 1'b1;
    step(0, 0, 0, 0, 1, 0, 1);
    idle(15, 1);
    e_st = S_PLAY2; e_rst = 1'b0; idle(1, 1);
    step(0, 1, 0, 0, 0, 0, 1); idle(1, 1);    // frozen cursor
    step(0, 0, 0, 1, 0, 0, 1); idle(1, 1);    // frozen speed
    e_st = S_RETURN; e_vga = 2'd0; e_rst = 1'b1;
    step(0, 0, 0, 0, 0, 1, 1);
    e_st = S_MENU; idle(1, 1);

    // PLAY1, exit while right held
    e_ch = 2'd0; step(1, 0, 0, 0, 0, 0, 1); idle(1, 1);
    e_st = S_LAUNCH; e_vga = 2'd1; step(0, 0, 0, 0, 1, 0, 1);
    idle(15, 0);
    e_st = S_PLAY1; e_rst = 1'b0; idle(1, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    e_st = S_RETURN; e_vga = 2'd0; e_rst = 1'b1;
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 1);                // still held: stay in RETURN
    e_st = S_MENU; idle(1, 1);                // speed still 3
    idle(1, 1);

    // Exit in MENU ignored
    step(0, 0, 0, 0, 0, 1, 1); idle(1, 1);

    // Start and down together with choice 0 -> game 1, choice unchanged
    e_st = S_LAUNCH; e_vga = 2'd1; step(0, 1, 0, 0, 1, 0, 1);
    idle(4, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;                             // asynchronous reset mid-LAUNCH
    #1;
    chk_val("async_rst state", state, S_MENU);
    chk_val("async_rst vgaMUX", vga, 0);
    chk_val("async_rst gamein_rst", grst, 1);
    chk_val("async_rst speed", speed, 8);
    chk_val("async_rst choice", choice, 0);
    set_reset_exp();
    idle(1, 1);
    @(negedge clk); rst_n = 1'b1;
    idle(1, 1);

    // Exit during LAUNCH abandons the count
    e_st = S_LAUNCH; e_vga = 2'd1; step(0, 0, 0, 0, 1, 0, 1);
    idle(1, 1);
    e_st = S_RETURN; e_vga = 2'd0; step(0, 0, 0, 0, 0, 1, 1);
    e_st = S_MENU; idle(1, 1);

    repeat (3) @(negedge clk);
    chk_val("scoreboard drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_menu_ctrl.md
GAME_MENU_CTRL -- requirements
Module: game_menu_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, is the number of sys_clk cycles gamein_rst stays asserted in LAUNCH (legal range 1..65535).
REQ-002 Parameter SPEED_RESET, default 8, is the reset value of speedcontrol (legal range 1..15).
REQ-003 Port sys_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports button_up, button_down, button_left and button_right, input, 1 bit each: debounced button levels, active-high.
REQ-006 Port start_in, input, 1 bit: debounced confirm button level, active-high.
REQ-007 Port exit, input, 1 bit: exit request level, active-high.
REQ-008 Port vgaMUX, output, 2 bits: display source; 0 = menu background, 1 = game 1, 2 = game 2, and 3 is never driven.
REQ-009 Port choice, output, 2 bits: menu cursor; 0 = game 1, 1 = game 2, and values 2 and 3 are never driven.
REQ-010 Port gamein_rst, output, 1 bit: active-high reset to both games.
REQ-011 Port speedcontrol, output, 4 bits: game speed setting, range 1..15.
REQ-012 Port state_o, output, 3 bits: current state encoding, for debug.

Function
REQ-013 Every output SHALL be registered.
- Every output changes exactly one cycle after the input edge that causes the change.
REQ-014 A rising edge SHALL be defined as the input being 1 in the current sample and 0 in the previous registered sample.
- Levels held high do not repeat the event.
REQ-015 States SHALL be MENU, LAUNCH, PLAY1, PLAY2 and RETURN.
REQ-016 In MENU, outputs SHALL be vgaMUX=0 and gamein_rst=1.
REQ-017 In MENU, a rising edge on up SHALL decrement choice with wrap, so 0 goes to 1.
- A rising edge on down SHALL increment choice with wrap, so 1 goes to 0.
- Simultaneous up and down edges SHALL leave choice unchanged.
REQ-018 In MENU, a rising edge on right SHALL increment speedcontrol, saturating at 15.
- A rising edge on left SHALL decrement speedcontrol, saturating at 1.
- Simultaneous left and right edges SHALL leave speedcontrol unchanged.
REQ-019 In MENU, a rising edge on start_in SHALL transition to LAUNCH and latch the target game from the current choice.
- A cursor edge in the same cycle SHALL be ignored.
REQ-020 In LAUNCH, gamein_rst SHALL stay 1 and vgaMUX SHALL already show the target game.
- A counter SHALL count RST_CYCLES cycles, then transition to PLAY1 (target 0) or PLAY2 (target 1).
REQ-021 In PLAY1 and PLAY2, gamein_rst=0 and vgaMUX SHALL be 1 or 2 respectively.
- choice and speedcontrol SHALL be frozen.
- Button edges SHALL have no effect.
REQ-022 A rising edge on exit in LAUNCH, PLAY1 or PLAY2 SHALL transition to RETURN.
- In LAUNCH, the counter is abandoned.
REQ-023 In RETURN, outputs SHALL be vgaMUX=0 and gamein_rst=1.
- The block SHALL transition to MENU on the first cycle in which all five buttons and exit are sampled low.
REQ-024 Edges in the first cycle back in MENU SHALL count only if the input was low in the prior sample.
- No carry-over of presses held during RETURN.
REQ-025 An exit edge in MENU SHALL be ignored.

Reset
REQ-026 While sys_rst_n=0, the block SHALL be in state MENU with vgaMUX=0, choice=0, gamein_rst=1, speedcontrol=SPEED_RESET, the launch counter at 0 and all edge-history registers at 0.
REQ-027 Reset assertion SHALL take effect asynchronously in any state, including mid-LAUNCH, and release SHALL be sampled on the next sys_clk rising edge.

Structure
REQ-028 A shared package SHALL hold the state encoding (MENU=0, LAUNCH=1, PLAY1=2, PLAY2=3, RETURN=4) and the vgaMUX source codes (BG=0, GAME1=1, GAME2=2).
REQ-029 Rising-edge detection SHALL be one sub-module, btn_edge, with one 1-bit instance per input: up, down, left, right, start_in and exit.
REQ-030 The launch counter SHALL be 16 bits wide.

Verification
REQ-031 Scenario 1: reset, then one down edge -> choice=1; another down edge -> choice=0; an up edge -> choice=1.
REQ-032 Scenario 2: 10 right edges from reset -> speedcontrol=15; 20 left edges -> speedcontrol=1.
REQ-033 Scenario 3: choice=1, then a start edge -> vgaMUX=2 with gamein_rst=1 for exactly 16 cycles, then gamein_rst=0 and state_o=PLAY2.
REQ-034 Scenario 4: in PLAY1, exit rises while right is held -> vgaMUX=0, state RETURN; after both are released -> MENU with speedcontrol unchanged.
REQ-035 Scenario 5: start and down rise in the same cycle with choice=0 -> target is game 1 and choice stays 0.
REQ-036 Scenario 6: sys_rst_n pulsed low at LAUNCH cycle 5 -> outputs return immediately to reset values without waiting for a clock.
